// File: rtl/rw_put_pkg.sv
// rtl/rw_put_pkg.sv - shared tag encoding, reset constants and width helper for the put/get accumulator
package rw_put_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EMIT = 2'd1,
    HALT = 2'd2
  } tag_t;

  localparam tag_t TAG_RST = ACC;

  // The counter must hold the value N itself while the sum is being emitted.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rw_put_step.sv
// rtl/rw_put_step.sv - combinational step: (state, input) -> (cont, out_valid, out_data, next state)
module rw_put_step
  import rw_put_pkg::*;
#(
  parameter  int DW           = 8,
  parameter  int N            = 4,
  parameter  int HALT_ON_ZERO = 1,
  localparam int CW           = cnt_w(N)
) (
  input  tag_t          i_tag,
  input  logic [DW-1:0] i_acc,
  input  logic [CW-1:0] i_cnt,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          cont,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output tag_t          o_tag,
  output logic [DW-1:0] o_acc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] w_cnt_inc;
  logic          w_burst_done;
  logic          w_halt_now;

  assign w_cnt_inc    = i_cnt + CW'(1);
  assign w_burst_done = (w_cnt_inc == CW'(N));
  assign w_halt_now   = (HALT_ON_ZERO != 0) && (i_acc == '0);

  // Moore outputs: decoded purely from the current state.
  assign out_data  = i_acc;
  assign out_valid = (i_tag == EMIT);
  assign cont      = (i_tag != HALT);

  always_comb begin
    o_tag = i_tag;
    o_acc = i_acc;
    o_cnt = i_cnt;
    case (i_tag)
      ACC: begin
        if (in_valid) begin
          o_acc = i_acc + in_data;
          o_cnt = w_cnt_inc;
          if (w_burst_done) begin
            o_tag = EMIT;
          end
        end
      end
      EMIT: begin
        if (w_halt_now) begin
          o_tag = HALT;
        end else if (in_valid) begin
          // A put in the emit cycle starts the next burst instead of zeroing.
          o_acc = in_data;
          o_cnt = CW'(1);
          o_tag = (N == 1) ? EMIT : ACC;
        end else begin
          o_acc = '0;
          o_cnt = '0;
          o_tag = ACC;
        end
      end
      HALT: begin
        o_tag = HALT;
      end
      default: begin
        o_tag = TAG_RST;
        o_acc = '0;
        o_cnt = '0;
      end
    endcase
  end

endmodule

// File: rtl/rw_put_accum.sv
// rtl/rw_put_accum.sv - stream accumulator top: state register around the combinational step
module rw_put_accum
  import rw_put_pkg::*;
#(
  parameter int DW           = 8,
  parameter int N            = 4,
  parameter int HALT_ON_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          cont
);

  localparam int CW = cnt_w(N);

  typedef struct packed {
    tag_t          tag;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
  } state_t;

  localparam state_t ST_RST = '{tag: TAG_RST, acc: '0, cnt: '0};

  state_t r_state;
  state_t w_next;

  rw_put_step #(
    .DW          (DW),
    .N           (N),
    .HALT_ON_ZERO(HALT_ON_ZERO)
  ) u_step (
    .i_tag    (r_state.tag),
    .i_acc    (r_state.acc),
    .i_cnt    (r_state.cnt),
    .in_valid (in_valid),
    .in_data  (in_data),
    .cont     (cont),
    .out_valid(out_valid),
    .out_data (out_data),
    .o_tag    (w_next.tag),
    .o_acc    (w_next.acc),
    .o_cnt    (w_next.cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

endmodule

// File: tb/tb_rw_put_accum.sv
// tb/tb_rw_put_accum.sv - directed vector bench for rw_put_accum (default and N=1 configurations)
module tb_rw_put_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       cont;

  logic [7:0] d1_in = '0, d2_in = '0;
  logic       v1_in = 1'b0, v2_in = 1'b0;
  logic [7:0] d1_out, d2_out;
  logic       v1_out, v2_out, c1_out, c2_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rw_put_accum #(.DW(8), .N(4), .HALT_ON_ZERO(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .cont(cont)
  );

  rw_put_accum #(.DW(8), .N(1), .HALT_ON_ZERO(1)) dut_n1 (
    .clk(clk), .rst(rst), .in_data(d1_in), .in_valid(v1_in),
    .out_data(d1_out), .out_valid(v1_out), .cont(c1_out)
  );

  rw_put_accum #(.DW(8), .N(1), .HALT_ON_ZERO(0)) dut_n1_nohalt (
    .clk(clk), .rst(rst), .in_data(d2_in), .in_valid(v2_in),
    .out_data(d2_out), .out_valid(v2_out), .cont(c2_out)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic v, input logic [7:0] d, input logic c,
                      input logic ev, input logic [7:0] ed, input logic ec);
    chk({name, ".out_valid"}, {31'd0, v}, {31'd0, ev});
    chk({name, ".out_data"},  {24'd0, d}, {24'd0, ed});
    chk({name, ".cont"},      {31'd0, c}, {31'd0, ec});
  endtask

  // {rst, valid, data} driven this cycle; {ev, ed, ec} expected before the edge
  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic ev, input logic [7:0] ed, input logic ec);
    vec_t x;
    x = '{r, v, d, ev, ed, ec};
    tbl.push_back(x);
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk3("reset_main", out_valid, out_data, cont, 1'b0, 8'h00, 1'b1);
    chk3("reset_n1", v1_out, d1_out, c1_out, 1'b0, 8'h00, 1'b1);
    rst = 1'b0;

    // 1,2,3,4 back to back
    add(0,1,8'd1,  0,8'h00,1); add(0,1,8'd2,  0,8'h01,1);
    add(0,1,8'd3,  0,8'h03,1); add(0,1,8'd4,  0,8'h06,1);
    add(0,0,8'd0,  1,8'h0A,1); add(0,0,8'd0,  0,8'h00,1);
    // wrap-around: 200+100+0+0 = 300 mod 256
    add(0,1,8'd200,0,8'h00,1); add(0,1,8'd100,0,8'd200,1);
    add(0,1,8'd0,  0,8'h2C,1); add(0,1,8'd0,  0,8'h2C,1);
    add(0,0,8'd0,  1,8'h2C,1); add(0,0,8'd0,  0,8'h00,1);
    // 1..9 continuous: second burst starts in the emit cycle
    add(0,1,8'd1,  0,8'h00,1); add(0,1,8'd2,  0,8'h01,1);
    add(0,1,8'd3,  0,8'h03,1); add(0,1,8'd4,  0,8'h06,1);
    add(0,1,8'd5,  1,8'h0A,1); add(0,1,8'd6,  0,8'h05,1);
    add(0,1,8'd7,  0,8'h0B,1); add(0,1,8'd8,  0,8'h12,1);
    add(0,1,8'd9,  1,8'h1A,1);
    // reset mid-burst discards the partial sum and count
    add(1,0,8'd0,  0,8'h09,1); add(0,0,8'd0,  0,8'h00,1);
    // 1,2,3,4 with idle gaps
    add(0,1,8'd1,  0,8'h00,1); add(0,0,8'd0,  0,8'h01,1);
    add(0,1,8'd2,  0,8'h01,1); add(0,0,8'd0,  0,8'h03,1);
    add(0,1,8'd3,  0,8'h03,1); add(0,0,8'd0,  0,8'h06,1);
    add(0,1,8'd4,  0,8'h06,1); add(0,0,8'd0,  1,8'h0A,1);
    add(0,0,8'd0,  0,8'h00,1);
    // zero sum halts; inputs ignored until reset
    add(0,1,8'd0,  0,8'h00,1); add(0,1,8'd0,  0,8'h00,1);
    add(0,1,8'd0,  0,8'h00,1); add(0,1,8'd0,  0,8'h00,1);
    add(0,1,8'd5,  1,8'h00,1); add(0,1,8'd7,  0,8'h00,0);
    add(0,1,8'd9,  0,8'h00,0); add(1,0,8'd0,  0,8'h00,0);
    add(0,1,8'd1,  0,8'h00,1); add(0,1,8'd1,  0,8'h01,1);
    add(0,1,8'd1,  0,8'h02,1); add(0,1,8'd1,  0,8'h03,1);
    add(0,0,8'd0,  1,8'h04,1); add(0,0,8'd0,  0,8'h00,1);

    for (int i = 0; i < tbl.size(); i++) begin
      chk3($sformatf("vec%0d", i), out_valid, out_data, cont, tbl[i].ev, tbl[i].ed, tbl[i].ec);
      rst      = tbl[i].rst;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      @(negedge clk);
    end

    // Asynchronous reset during EMIT kills the pulse before the next edge
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
    in_valid = 1'b0;
    chk3("emit_before_rst", out_valid, out_data, cont, 1'b1, 8'h0A, 1'b1);
    #1 rst = 1'b1;
    #1 chk3("async_rst_emit", out_valid, out_data, cont, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset releases HALT immediately
    feed(8'd0); feed(8'd0); feed(8'd0); feed(8'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk3("halted", out_valid, out_data, cont, 1'b0, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #1 chk3("async_rst_halt", out_valid, out_data, cont, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // N=1: every valid input is its own burst
    v1_in = 1'b1; d1_in = 8'd7; v2_in = 1'b1; d2_in = 8'd0;
    @(negedge clk);
    chk3("n1_first", v1_out, d1_out, c1_out, 1'b1, 8'd7, 1'b1);
    chk3("nohalt_zero", v2_out, d2_out, c2_out, 1'b1, 8'd0, 1'b1);
    d1_in = 8'd9; v2_in = 1'b0;
    @(negedge clk);
    chk3("n1_second", v1_out, d1_out, c1_out, 1'b1, 8'd9, 1'b1);
    chk3("nohalt_after", v2_out, d2_out, c2_out, 1'b0, 8'd0, 1'b1);
    d1_in = 8'd0; v2_in = 1'b1; d2_in = 8'd3;
    @(negedge clk);
    chk3("n1_zero", v1_out, d1_out, c1_out, 1'b1, 8'd0, 1'b1);
    chk3("nohalt_three", v2_out, d2_out, c2_out, 1'b1, 8'd3, 1'b1);
    d1_in = 8'd5; v2_in = 1'b0;
    @(negedge clk);
    chk3("n1_halted", v1_out, d1_out, c1_out, 1'b0, 8'd0, 1'b0);
    chk3("nohalt_idle", v2_out, d2_out, c2_out, 1'b0, 8'd0, 1'b1);
    v1_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
